// File: rtl/dma_pkg.sv
// Shared definitions for the DMA stream path: packet width, default FIFO depth
// and the packet data type carried on the AXIS links.
package dma_pkg;

  localparam int AXIS_W        = 192;
  localparam int DEFAULT_DEPTH = 8;

  typedef logic [AXIS_W-1:0] axis_pkt_t;

endpackage

// File: rtl/axis_pkt_fifo_if.sv
// One AXIS packet link: data, valid and ready. The master drives data/valid,
// the slave drives ready.
interface axis_pkt_fifo_if;
  import dma_pkg::*;

  axis_pkt_t tdata;
  logic      tvalid;
  logic      tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/fifo_ram_2p.sv
// Simple dual-port storage array: one write port and one registered read port.
// A read of the address being written in the same cycle returns the new data,
// so the consumer never sees a stale head entry.
module fifo_ram_2p #(
  parameter  int W     = 192,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // Write port plus registered read with write-to-read forwarding.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/axis_pkt_fifo.sv
// First-word-fall-through packet FIFO between the DMA RX stream and the CGRA
// ingress. The output register is one of the DEPTH entries; the remaining
// entries live in fifo_ram_2p. A push into an empty output stage bypasses the
// RAM so data appears one cycle after it is accepted.
module axis_pkt_fifo
  import dma_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int AFULL_THRESH = DEPTH - 2,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_stats,
  axis_pkt_fifo_if.slave          s_axis,
  axis_pkt_fifo_if.master         m_axis,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    almost_full,
  output logic                    overflow_err,
  output logic [CNT_W-1:0]        pkt_in_cnt,
  output logic [CNT_W-1:0]        pkt_out_cnt,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_THRESH);

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next, ram_rd_addr;
  logic [LW-1:0] level_reg, level_next, ram_cnt;
  logic          tready_reg, out_valid_reg, afull_reg, ovf_reg;
  axis_pkt_t     out_data_reg, ram_rd_data;
  logic          push, pop, full, load_out, ram_has, ram_we, ram_re;
  logic [2:0]    cnt_inc;

  assign full     = (level_reg == FULL_LVL);
  assign push     = s_axis.tvalid & tready_reg;
  assign pop      = out_valid_reg & m_axis.tready;
  // Entries held in the RAM exclude the one sitting in the output register.
  assign ram_cnt  = level_reg - LW'(out_valid_reg);
  assign ram_has  = (ram_cnt != '0);
  assign load_out = !out_valid_reg || pop;
  assign ram_re   = load_out && ram_has;
  // A push goes to the RAM unless it can bypass straight into the output stage.
  assign ram_we   = push && !(load_out && !ram_has);
  assign rd_ptr_next = rd_ptr_reg + PW'(ram_re);
  assign ram_rd_addr = rst ? '0 : rd_ptr_next;
  assign level_next  = level_reg + LW'(push) - LW'(pop);

  fifo_ram_2p #(
    .W     (AXIS_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (wr_ptr_reg),
    .wr_data (s_axis.tdata),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  // Pointer, level, flag and output-stage state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      tready_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      afull_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      if (ram_we) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      tready_reg <= (level_next != FULL_LVL);
      afull_reg  <= (level_next >= AFULL_LVL);
      if (s_axis.tvalid && full) begin
        ovf_reg <= 1'b1;
      end
      if (load_out) begin
        out_valid_reg <= ram_has || push;
        if (ram_has) begin
          out_data_reg <= ram_rd_data;
        end else if (push) begin
          out_data_reg <= s_axis.tdata;
        end
      end
    end
  end

  // Counter events: bit 0 accepted ingress, bit 1 delivered egress, bit 2 stall.
  assign cnt_inc = {out_valid_reg && !m_axis.tready, pop, push};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    // Saturating status counter; clr_stats wins over a same-cycle increment.
    always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
        cnt_reg <= '0;
      end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign s_axis.tready = tready_reg;
  assign m_axis.tvalid = out_valid_reg;
  assign m_axis.tdata  = out_data_reg;
  assign level         = level_reg;
  assign almost_full   = afull_reg;
  assign overflow_err  = ovf_reg;
  assign pkt_in_cnt    = g_cnt[0].cnt_reg;
  assign pkt_out_cnt   = g_cnt[1].cnt_reg;
  assign stall_cnt     = g_cnt[2].cnt_reg;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo (DEPTH=8, 4-bit counters so saturation is
// reachable quickly).
module tb_axis_pkt_fifo;
  import dma_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_stats = 1'b0;
  logic [3:0] level;
  logic almost_full, overflow_err;
  logic [3:0] pkt_in_cnt, pkt_out_cnt, stall_cnt;
  int checks = 0;
  int errors = 0;

  axis_pkt_fifo_if s_if ();
  axis_pkt_fifo_if m_if ();

  axis_pkt_fifo #(
    .DEPTH        (8),
    .AFULL_THRESH (6),
    .CNT_W        (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clr_stats    (clr_stats),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .level        (level),
    .almost_full  (almost_full),
    .overflow_err (overflow_err),
    .pkt_in_cnt   (pkt_in_cnt),
    .pkt_out_cnt  (pkt_out_cnt),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic axis_pkt_t mk(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {24{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic do_reset();
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    clr_stats = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_tready", s_if.tready, 0);
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tdata", m_if.tdata, 0);
    chk("rst_level", level, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_cnts", {pkt_in_cnt, pkt_out_cnt, stall_cnt}, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_tready", s_if.tready, 1);

    // Pass-through
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s_if.tdata = mk(i);
      tick();
      chk("pt_tvalid", m_if.tvalid, 1);
      chk("pt_tdata", m_if.tdata, mk(i));
      chk("pt_level", level, 1);
    end
    s_if.tvalid = 1'b0;
    tick();
    chk("pt_drained", m_if.tvalid, 0);
    chk("pt_level0", level, 0);
    chk("pt_in_cnt", pkt_in_cnt, 3);
    chk("pt_out_cnt", pkt_out_cnt, 3);

    // Fill against back-pressure
    do_reset();
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_if.tdata = mk(16 + i);
      tick();
      chk("fill_level", level, i + 1);
      chk("fill_afull", almost_full, (i + 1 >= 6) ? 1 : 0);
      chk("fill_tready", s_if.tready, (i + 1 < 8) ? 1 : 0);
    end
    chk("fill_head", m_if.tdata, mk(16));
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    tick();
    chk("reopen_tready", s_if.tready, 1);
    chk("reopen_level", level, 7);
    chk("reopen_head", m_if.tdata, mk(17));

    // Refill to full while clearing stats in the same cycle
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata = mk(24);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("refull_level", level, 8);
    chk("refull_tready", s_if.tready, 0);
    chk("clr_prio_in", pkt_in_cnt, 0);

    // Stall and overflow while full
    s_if.tdata = mk(8'hEE);
    for (int i = 0; i < 4; i++) tick();
    s_if.tvalid = 1'b0;
    chk("ovf_flag", overflow_err, 1);
    chk("stall_cnt", stall_cnt, 4);
    chk("ovf_in_cnt", pkt_in_cnt, 0);
    chk("ovf_level", level, 8);
    chk("stall_data", m_if.tdata, mk(17));

    // Drain in order; overflow stays sticky
    m_if.tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_tvalid", m_if.tvalid, 1);
      chk("drain_tdata", m_if.tdata, mk(17 + k));
      tick();
    end
    chk("drain_empty", m_if.tvalid, 0);
    chk("drain_level", level, 0);
    chk("ovf_sticky", overflow_err, 1);
    chk("drain_out_cnt", pkt_out_cnt, 8);

    // Simultaneous push/pop at level 4 with pointer wrap
    do_reset();
    chk("ovf_cleared", overflow_err, 0);
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_if.tdata = mk(32 + i);
      tick();
    end
    chk("sim_level_start", level, 4);
    m_if.tready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_if.tdata = mk(36 + k);
      chk("sim_tdata", m_if.tdata, mk(32 + k));
      tick();
      chk("sim_level", level, 4);
    end
    s_if.tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("sim_tail_tvalid", m_if.tvalid, 1);
      chk("sim_tail_tdata", m_if.tdata, mk(42 + k));
      tick();
    end
    chk("sim_empty", m_if.tvalid, 0);

    // Reset mid-stream
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_if.tdata = mk(8'h50 + i);
      tick();
    end
    chk("mid_level5", level, 5);
    s_if.tvalid = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_tvalid", m_if.tvalid, 0);
    chk("mid_level", level, 0);
    chk("mid_cnts", {pkt_in_cnt, pkt_out_cnt, stall_cnt}, 0);
    chk("mid_ovf", overflow_err, 0);
    rst = 1'b0;
    tick();
    s_if.tvalid = 1'b1;
    s_if.tdata = mk(8'h77);
    tick();
    s_if.tvalid = 1'b0;
    chk("mid_first_valid", m_if.tvalid, 1);
    chk("mid_first_data", m_if.tdata, mk(8'h77));

    // Counter saturation and clear
    do_reset();
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_if.tdata = mk(i);
      tick();
    end
    chk("sat_in_cnt", pkt_in_cnt, 15);
    chk("sat_out_cnt", pkt_out_cnt, 15);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_in_cnt", pkt_in_cnt, 0);
    chk("clr_out_cnt", pkt_out_cnt, 0);
    tick();
    s_if.tvalid = 1'b0;
    chk("post_clr_in_cnt", pkt_in_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO for whole 192b AXIS packets.
- Sits directly downstream of the duplex DMA's Memory->CGRA stream (DMA s_axis_* output) and upstream of the CGRA ingress port.
- Absorbs CGRA back-pressure so the DMA can keep issuing AR bursts without stalling R beats.
- Exposes occupancy and throughput counters for MMIO status registers.

Parameters:
- AXIS_W, 192, packet width in bits (one AXIS transfer = one packet).
- DEPTH, 8, number of packet entries; power of two, >= 2.
- AFULL_THRESH, DEPTH-2, level at or above which almost_full is asserted.
- CNT_W, 32, width of the status counters.

Ports:
- clk  in  1  Single clock for all logic.
- rst  in  1  Synchronous, active-high reset.
- clr_stats  in  1  Synchronous pulse; clears pkt_in_cnt, pkt_out_cnt and stall_cnt only.
- s_axis_tdata  in  AXIS_W  Ingress packet data (from the DMA RX stream).
- s_axis_tvalid  in  1  Ingress valid.
- s_axis_tready  out  1  Ingress ready.
- m_axis_tdata  out  AXIS_W  Egress packet data (to the CGRA).
- m_axis_tvalid  out  1  Egress valid.
- m_axis_tready  in  1  Egress ready.
- level  out  $clog2(DEPTH)+1  Current number of stored packets.
- almost_full  out  1  Asserted when level >= AFULL_THRESH.
- overflow_err  out  1  Sticky flag for a push attempt while full.
- pkt_in_cnt  out  CNT_W  Count of accepted ingress packets.
- pkt_out_cnt  out  CNT_W  Count of delivered egress packets.
- stall_cnt  out  CNT_W  Cycles with m_axis_tvalid=1 and m_axis_tready=0.

Behaviour:
- Clocking and reset: one clock clk; reset rst is synchronous and active-high.
- On rst, in the same edge:
  - write/read pointers = 0; level = 0.
  - s_axis_tready = 0 during the reset cycle, then 1 on the first cycle after rst deasserts.
  - m_axis_tvalid = 0; m_axis_tdata = 0.
  - almost_full = 0, overflow_err = 0, all counters = 0.
- Reset mid-operation discards all stored packets. Storage RAM contents need not be cleared.
- Push = s_axis_tvalid & s_axis_tready. Pop = m_axis_tvalid & m_axis_tready.
- s_axis_tready = !full, registered:
  - Computed from next-state level, so there is no combinational path from m_axis_tready to s_axis_tready.
  - When full, a pop in cycle N reopens s_axis_tready in cycle N+1.
- FWFT with a registered output stage:
  - A push into an empty FIFO gives m_axis_tvalid=1 and m_axis_tdata=pushed data on the next cycle (latency 1).
  - The output register holds its data stable while m_axis_tvalid=1 and m_axis_tready=0.
- Simultaneous push and pop:
  - When not empty and not full: level is unchanged and both transfers complete.
  - When empty: no pop is possible; a push alone occurs.
  - When full: s_axis_tready is 0, so a pop alone occurs.
- Level arithmetic: level_next = level + push - pop. It is in range 0..DEPTH and does not wrap.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Full is level == DEPTH; empty is level == 0. The output register counts as one of the DEPTH entries.
- almost_full and level are registered and update on the same edge as the push/pop.
- overflow_err:
  - Set when s_axis_tvalid=1 and full. This is not an error by itself, but the DMA ignores tready during its last R beat, so it is flagged.
  - Cleared only by rst.
  - The data in that case is dropped and not counted.
- Counters:
  - pkt_in_cnt +1 per push; pkt_out_cnt +1 per pop; stall_cnt +1 per stall cycle.
  - All three saturate at 2^CNT_W-1 and never wrap.
  - clr_stats has priority over an increment in the same cycle (result is 0).
- Ordering is strict FIFO with no reordering or merging; data passes bit-exact.

Decomposition:
- Shared package dma_pkg holds AXIS_W, the default DEPTH, and the typedef axis_pkt_t = logic [AXIS_W-1:0].
- One sub-module: fifo_ram_2p, a simple dual-port register array (1 write port, 1 synchronous read port), reusable on the TX side.
- Pointer/level control, output register, and counters stay in axis_pkt_fifo.

Test Plan:
- Pass-through: push 3 packets 0x…01/0x…02/0x…03 with m_axis_tready=1 -> each appears one cycle after push, in order; level never exceeds 1; pkt_in_cnt=pkt_out_cnt=3.
- Fill/back-pressure (DEPTH=8): m_axis_tready=0, push continuously -> s_axis_tready drops after the 8th push; level=8; almost_full high from level 6.
  - Then raise m_axis_tready for one cycle -> s_axis_tready=1 on the following cycle; level 7.
- Stall and overflow: hold full and drive s_axis_tvalid=1 for 4 cycles with m_axis_tready=0 -> overflow_err=1 (sticky); stall_cnt=4; pkt_in_cnt unchanged; output data stable.
- Simultaneous push/pop at level 4 for 10 cycles with an incrementing pattern -> level stays 4; output sequence strictly in order; pointers wrap cleanly past DEPTH.
- Reset mid-stream: level=5, assert rst one cycle -> next cycle m_axis_tvalid=0, level=0, counters 0, overflow_err=0; the first new push emerges as the first output.
- Counter saturation/clear: force CNT_W=4, push 20 packets -> pkt_in_cnt=15 (saturated); clr_stats together with a push -> pkt_in_cnt=0.
